ssd_capture: RTL and testbench

Reader for the multiplexed seven-segment display bus: it samples the active-low segment lines and active-low anode strobes that the display path drives. It waits for each strobe to settle, then converts each segment pattern back to its 4-bit hex value. It assembles the digits into one word, flags a complete frame once every digit has been seen, and flags illegal patterns. Used as an on-chip display monitor and as a self-check block behind the display driver.

---
 rtl/ssd_capture_if.sv | 31 +++
 rtl/ssd_capture.sv | 130 +++++++++++++
 tb/tb_ssd_capture.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_capture_if.sv
//------------------------------------------------------------------------------
// ssd_capture_if : seven-segment display bus plus capture results
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ssd_capture_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          in_SSD;
  logic [DIGITS-1:0]   in_AN;
  logic [4*DIGITS-1:0] out_HEX;
  logic [DIGITS-1:0]   out_digit_valid;
  logic [DIGITS-1:0]   out_blank;
  logic                out_frame_valid;
  logic                out_err;

  // Display-driver side: drives the bus, observes the capture results.
  modport master (
    output in_SSD, in_AN,
    input  out_HEX, out_digit_valid, out_blank, out_frame_valid, out_err
  );

  // Capture side.
  modport slave (
    input  in_SSD, in_AN,
    output out_HEX, out_digit_valid, out_blank, out_frame_valid, out_err
  );
endinterface

`default_nettype wire

// File: rtl/ssd_capture.sv
//------------------------------------------------------------------------------
// ssd_capture : settles and decodes a multiplexed seven-segment bus into hex
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ssd_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  wire logic     clk,
  input  wire logic     reset,
  ssd_capture_if.slave  bus
);

  localparam int         SELW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int         PW       = DIGITS + 7;
  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    HELD   = 1'b1
  } state_t;

  state_t                state;
  logic [PW-1:0]         samp;
  logic [7:0]            cnt;
  logic [DIGITS-1:0]     seen;
  logic [4*DIGITS-1:0]   hex;
  logic [DIGITS-1:0]     digit_valid;
  logic [DIGITS-1:0]     blank;
  logic                  frame_valid;
  logic                  err;

  logic [PW-1:0]         pat;
  logic [DIGITS-1:0]     an_low;
  logic                  multi;
  logic [SELW-1:0]       sel;
  logic                  is_blank;
  logic                  legal;
  logic [3:0]            nib;

  assign pat = {bus.in_AN, bus.in_SSD};

  // Decode works on the settled sample, which equals pat whenever it is used.
  always_comb begin
    an_low   = ~samp[PW-1:7];
    multi    = (an_low & (an_low - DIGITS'(1))) != '0;
    sel      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_low[i]) sel = SELW'(i);
    end
    is_blank = (samp[6:0] == 7'b1111111);
    legal    = 1'b1;
    nib      = 4'h0;
    case (samp[6:0])
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      default:    legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SETTLE;
      samp        <= {{DIGITS{1'b1}}, 7'b1111111};
      cnt         <= 8'd0;
      seen        <= '0;
      hex         <= '0;
      digit_valid <= '0;
      blank       <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err         <= 1'b0;
      if (pat != samp) begin
        samp  <= pat;
        cnt   <= 8'd0;
        state <= SETTLE;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
        if (state == SETTLE && cnt == CNT_LAST) begin
          state <= HELD;
          if (an_low == '0) begin
            // display dark: nothing to capture
          end else if (multi) begin
            err <= 1'b1;
          end else if (is_blank || legal) begin
            hex[4*sel +: 4]  <= is_blank ? 4'h0 : nib;
            digit_valid[sel] <= 1'b1;
            blank[sel]       <= is_blank;
            if ((seen | an_low) == {DIGITS{1'b1}}) begin
              frame_valid <= 1'b1;
              seen        <= '0;
            end else begin
              seen <= seen | an_low;
            end
          end else begin
            err <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.out_HEX         = hex;
  assign bus.out_digit_valid = digit_valid;
  assign bus.out_blank       = blank;
  assign bus.out_frame_valid = frame_valid;
  assign bus.out_err         = err;

endmodule

`default_nettype wire

// File: tb/tb_ssd_capture.sv
//------------------------------------------------------------------------------
// tb_ssd_capture : scoreboard bench for ssd_capture (4 digits, 4 stable cycles)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ssd_capture;

  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ssd_capture_if #(.DIGITS(4)) bus ();

  ssd_capture #(.DIGITS(4), .STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  dv;
    logic [3:0]  blank;
    logic        fv;
    logic        er;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   fv_cnt = 0;
  int   err_cnt = 0;

  logic [6:0] seg_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: a pattern is captured once it has been seen on STABLE+1
  // consecutive edges; run counts those edges.
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_hex [4];
  logic [3:0]  m_dv, m_blank, m_seen;

  always @(posedge clk) begin
    exp_t       e;
    logic [3:0] lows;
    int         k, nv;
    e.fv = 1'b0;
    e.er = 1'b0;
    if (reset) begin
      for (int i = 0; i < 4; i++) m_hex[i] = 4'h0;
      m_dv = 4'h0; m_blank = 4'h0; m_seen = 4'h0;
      m_prev = {4'hF, 7'h7F};
      m_run = 1;
    end else if ({bus.in_AN, bus.in_SSD} != m_prev) begin
      m_prev = {bus.in_AN, bus.in_SSD};
      m_run = 1;
    end else begin
      if (m_run == STABLE) begin
        lows = ~bus.in_AN;
        if ($countones(lows) > 1) begin
          e.er = 1'b1;
        end else if ($countones(lows) == 1) begin
          k = 0;
          for (int i = 0; i < 4; i++) if (lows[i]) k = i;
          nv = -1;
          for (int v = 0; v < 16; v++) if (seg_tbl[v] == bus.in_SSD) nv = v;
          if (bus.in_SSD == 7'h7F) begin
            m_hex[k] = 4'h0; m_blank[k] = 1'b1; m_dv[k] = 1'b1; m_seen[k] = 1'b1;
          end else if (nv >= 0) begin
            m_hex[k] = nv[3:0]; m_blank[k] = 1'b0; m_dv[k] = 1'b1; m_seen[k] = 1'b1;
          end else begin
            e.er = 1'b1;
          end
          if (m_seen == 4'hF) begin
            e.fv = 1'b1;
            m_seen = 4'h0;
          end
        end
      end
      if (m_run <= STABLE) m_run++;
    end
    e.hex   = {m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
    e.dv    = m_dv;
    e.blank = m_blank;
    q.push_back(e);
  end

  // Monitor: compares DUT outputs after every edge with the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (bus.out_HEX !== e.hex || bus.out_digit_valid !== e.dv ||
          bus.out_blank !== e.blank || bus.out_frame_valid !== e.fv ||
          bus.out_err !== e.er) begin
        errors++;
        $display("FAIL scoreboard t=%0t actual hex=%h dv=%b blank=%b fv=%b err=%b required hex=%h dv=%b blank=%b fv=%b err=%b",
                 $time, bus.out_HEX, bus.out_digit_valid, bus.out_blank, bus.out_frame_valid,
                 bus.out_err, e.hex, e.dv, e.blank, e.fv, e.er);
      end
      if (bus.out_frame_valid === 1'b1) fv_cnt++;
      if (bus.out_err === 1'b1) err_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] ssd, input int n);
    bus.in_AN  = an;
    bus.in_SSD = ssd;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic scan();
    drive(4'b1110, 7'b1001111, 6);
    drive(4'b1101, 7'b0010010, 6);
    drive(4'b1011, 7'b0000110, 6);
    drive(4'b0111, 7'b1001100, 6);
  endtask

  initial begin
    int fv0, er0;
    logic [3:0] an;
    logic [6:0] ssd;
    bus.in_AN  = 4'hF;
    bus.in_SSD = 7'h7F;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    chk("reset_hex", 32'(bus.out_HEX), 32'h0);
    chk("reset_dv", 32'(bus.out_digit_valid), 32'h0);

    drive(4'b1110, 7'b0100100, 5);
    chk("hold5_hex", 32'(bus.out_HEX[3:0]), 32'h5);
    chk("hold5_dv", 32'(bus.out_digit_valid), 32'h1);
    er0 = err_cnt;
    drive(4'b1110, 7'b0100100, 20);
    chk("hold20_err", 32'(err_cnt - er0), 32'h0);

    do_reset();
    drive(4'b1110, 7'b0100100, 4);
    drive(4'b1111, 7'h7F, 3);
    chk("glitch_hex", 32'(bus.out_HEX), 32'h0);
    chk("glitch_dv", 32'(bus.out_digit_valid), 32'h0);

    fv0 = fv_cnt;
    scan();
    chk("scan_hex", 32'(bus.out_HEX), 32'h4321);
    chk("scan_fv1", 32'(fv_cnt - fv0), 32'h1);
    scan();
    chk("scan_fv2", 32'(fv_cnt - fv0), 32'h2);

    er0 = err_cnt;
    drive(4'b1101, 7'b1111110, 5);
    chk("illegal_err", 32'(err_cnt - er0), 32'h1);
    chk("illegal_hex", 32'(bus.out_HEX[7:4]), 32'h2);
    drive(4'b1100, 7'b0000001, 5);
    chk("multi_err", 32'(err_cnt - er0), 32'h2);
    chk("multi_hex", 32'(bus.out_HEX), 32'h4321);

    drive(4'b1011, 7'h7F, 5);
    chk("blank_bit", 32'(bus.out_blank), 32'h4);
    chk("blank_hex", 32'(bus.out_HEX[11:8]), 32'h0);
    drive(4'b1011, 7'b0110001, 5);
    chk("unblank_hex", 32'(bus.out_HEX[11:8]), 32'hC);
    chk("unblank_bit", 32'(bus.out_blank), 32'h0);

    drive(4'b1110, 7'b1001111, 6);
    drive(4'b1101, 7'b0010010, 6);
    drive(4'b1011, 7'b0000110, 6);
    do_reset();
    chk("midreset_hex", 32'(bus.out_HEX), 32'h0);
    fv0 = fv_cnt;
    drive(4'b0111, 7'b1001100, 6);
    chk("midreset_fv", 32'(fv_cnt - fv0), 32'h0);
    chk("midreset_dv", 32'(bus.out_digit_valid), 32'h8);

    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0:       an = 4'hF;
        1:       an = ~(4'b0011 << $urandom_range(0, 2));
        default: an = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 9))
        0:       ssd = 7'h7F;
        1:       ssd = 7'($urandom);
        default: ssd = seg_tbl[$urandom_range(0, 15)];
      endcase
      if ($urandom_range(0, 39) == 0) do_reset();
      drive(an, ssd, $urandom_range(1, 8));
    end

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
